// File: rtl/weight_preload_controller.sv
// Weight memory preload: zero-clears the weight memory, streams NUM_WORDS words in over
// valid/ready, then verifies a 16-bit additive checksum before flagging the weights as loaded.
module weight_preload_controller #(
  parameter int WIDTH         = 16,
  parameter int ADDR_WIDTH    = 14,
  parameter int MEM_DEPTH     = 16384,
  parameter int NUM_WORDS     = 12000,
  parameter int TIMEOUT_LIMIT = 100000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      expected_checksum,
  input  logic                  s_valid,
  input  logic [WIDTH-1:0]      s_data,
  output logic                  s_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0]      mem_wdata,
  output logic                  memory_ready,
  output logic                  weights_loaded,
  output logic                  load_error,
  output logic [ADDR_WIDTH:0]   words_loaded,
  output logic [WIDTH-1:0]      checksum
);

  localparam int CNT_W  = ADDR_WIDTH + 1;
  localparam int IDLE_W = $clog2(TIMEOUT_LIMIT + 1);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_DEPTH - 1);
  localparam logic [CNT_W-1:0]      LAST_WORD = CNT_W'(NUM_WORDS - 1);
  localparam logic [IDLE_W-1:0]     IDLE_LAST = IDLE_W'(TIMEOUT_LIMIT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_LOAD, S_VERIFY, S_READY, S_ERROR
  } state_e;

  state_e state_q, state_d;

  logic                  mem_we_q,    mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q,  mem_addr_d;
  logic [WIDTH-1:0]      mem_wdata_q, mem_wdata_d;
  logic [CNT_W-1:0]      words_q,     words_d;
  logic [WIDTH-1:0]      checksum_q,  checksum_d;
  logic [IDLE_W-1:0]     idle_q,      idle_d;

  logic beat;
  assign beat = s_valid && (state_q == S_LOAD);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // NOTE: each combinational block assigns defaults first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_CLEAR;
      S_CLEAR: if (mem_addr_q == LAST_ADDR) state_d = S_LOAD;
      S_LOAD: begin
        if (beat && (words_q == LAST_WORD))       state_d = S_VERIFY;
        else if (!beat && (idle_q == IDLE_LAST))  state_d = S_ERROR;
      end
      S_VERIFY: state_d = (checksum_q == expected_checksum) ? S_READY : S_ERROR;
      S_READY, S_ERROR: if (start) state_d = S_CLEAR;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    s_ready        = 1'b0;
    memory_ready   = 1'b0;
    weights_loaded = 1'b0;
    load_error     = 1'b0;
    case (state_q)
      S_LOAD:   begin s_ready = 1'b1; memory_ready = 1'b1; end
      S_VERIFY: memory_ready = 1'b1;
      S_READY:  begin memory_ready = 1'b1; weights_loaded = 1'b1; end
      S_ERROR:  begin memory_ready = 1'b1; load_error = 1'b1; end
      default:  ;
    endcase
  end

  // Memory port is registered; the first clear write is issued on the edge that enters CLEAR.
  always_comb begin
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    words_d     = words_q;
    checksum_d  = checksum_q;
    idle_d      = idle_q;
    case (state_q)
      S_IDLE, S_READY, S_ERROR: begin
        if ((state_q == S_IDLE) || start) begin
          mem_we_d    = start;
          mem_addr_d  = '0;
          mem_wdata_d = '0;
          words_d     = '0;
          checksum_d  = '0;
          idle_d      = '0;
        end
      end
      S_CLEAR: begin
        if (mem_addr_q != LAST_ADDR) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = mem_addr_q + ADDR_WIDTH'(1);
          mem_wdata_d = '0;
        end
      end
      S_LOAD: begin
        if (beat) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = words_q[ADDR_WIDTH-1:0];
          mem_wdata_d = s_data;
          words_d     = words_q + CNT_W'(1);
          checksum_d  = checksum_q + s_data;
          idle_d      = '0;
        end else begin
          idle_d = idle_q + IDLE_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      words_q     <= '0;
      checksum_q  <= '0;
      idle_q      <= '0;
    end else begin
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      words_q     <= words_d;
      checksum_q  <= checksum_d;
      idle_q      <= idle_d;
    end
  end

  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign words_loaded = words_q;
  assign checksum     = checksum_q;

endmodule

// File: tb/tb_weight_preload_controller.sv
// Bench for weight_preload_controller with a small memory: directed steps plus random weight sets,
// scored against a shadow of every memory write and a plain-arithmetic checksum model.
module tb_weight_preload_controller;

  localparam int WIDTH = 16;
  localparam int AW    = 14;
  localparam int DEPTH = 8;
  localparam int NW    = 4;
  localparam int TLIM  = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [WIDTH-1:0] expected_checksum;
  logic            s_valid;
  logic [WIDTH-1:0] s_data;
  logic            s_ready;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [WIDTH-1:0] mem_wdata;
  logic            memory_ready;
  logic            weights_loaded;
  logic            load_error;
  logic [AW:0]     words_loaded;
  logic [WIDTH-1:0] checksum;

  weight_preload_controller #(
    .WIDTH(WIDTH), .ADDR_WIDTH(AW), .MEM_DEPTH(DEPTH), .NUM_WORDS(NW), .TIMEOUT_LIMIT(TLIM)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .expected_checksum(expected_checksum),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .memory_ready(memory_ready), .weights_loaded(weights_loaded), .load_error(load_error),
    .words_loaded(words_loaded), .checksum(checksum)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Shadow of the weight memory, poisoned so a missed clear write shows up.
  logic [WIDTH-1:0] shadow [DEPTH] = '{default: 16'hDEAD};
  logic             bad_addr = 1'b0;

  always @(negedge clk) begin
    if (mem_we) begin
      if (mem_addr < AW'(DEPTH)) shadow[mem_addr[2:0]] <= mem_wdata;
      else                       bad_addr <= 1'b1;
    end
  end

  logic [WIDTH-1:0] w [NW];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] model_sum();
    logic [WIDTH-1:0] s;
    s = '0;
    for (int i = 0; i < NW; i++) s = s + w[i];
    return s;
  endfunction

  task automatic check_reset_state(input string tag);
    check({tag, "_s_ready"},  32'(s_ready), 0);
    check({tag, "_mem_we"},   32'(mem_we), 0);
    check({tag, "_mem_addr"}, 32'(mem_addr), 0);
    check({tag, "_mem_wdata"}, 32'(mem_wdata), 0);
    check({tag, "_mem_rdy"},  32'(memory_ready), 0);
    check({tag, "_w_loaded"}, 32'(weights_loaded), 0);
    check({tag, "_ld_err"},   32'(load_error), 0);
    check({tag, "_words"},    32'(words_loaded), 0);
    check({tag, "_csum"},     32'(checksum), 0);
  endtask

  // Pulse start, then expect one zero write per cycle over the whole memory.
  task automatic start_and_clear(input bit poke);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("clr_words0",  32'(words_loaded), 0);
    check("clr_csum0",   32'(checksum), 0);
    check("clr_memrdy0", 32'(memory_ready), 0);
    check("clr_wload0",  32'(weights_loaded), 0);
    check("clr_lderr0",  32'(load_error), 0);
    for (int k = 0; k < DEPTH; k++) begin
      check($sformatf("clr_we%0d", k),    32'(mem_we), 1);
      check($sformatf("clr_addr%0d", k),  32'(mem_addr), k);
      check($sformatf("clr_wdata%0d", k), 32'(mem_wdata), 0);
      check($sformatf("clr_sready%0d", k), 32'(s_ready), 0);
      start = (poke && k == 3);
      tick();
    end
    start = 1'b0;
    check("clr_done_memrdy", 32'(memory_ready), 1);
    check("clr_done_sready", 32'(s_ready), 1);
    check("clr_done_we",     32'(mem_we), 0);
    for (int k = 0; k < DEPTH; k++)
      check($sformatf("clr_shadow%0d", k), 32'(shadow[k]), 0);
  endtask

  // Offer one beat from the current LOAD cycle and check the write it produces next cycle.
  task automatic send_beat(input int i, input logic [WIDTH-1:0] run_sum, input bit poke);
    s_valid = 1'b1;
    s_data  = w[i];
    start   = poke;
    check($sformatf("ld_sready%0d", i), 32'(s_ready), 1);
    tick();
    start   = 1'b0;
    s_valid = 1'b0;
    check($sformatf("ld_we%0d", i),    32'(mem_we), 1);
    check($sformatf("ld_addr%0d", i),  32'(mem_addr), i);
    check($sformatf("ld_wdata%0d", i), 32'(mem_wdata), 32'(w[i]));
    check($sformatf("ld_words%0d", i), 32'(words_loaded), i + 1);
    check($sformatf("ld_csum%0d", i),  32'(checksum), 32'(run_sum));
  endtask

  task automatic run_load(input logic [WIDTH-1:0] exp_sum, input int gap, input bit poke);
    logic [WIDTH-1:0] sum;
    bit pass;
    sum = '0;
    expected_checksum = exp_sum;
    for (int i = 0; i < NW; i++) begin
      for (int g = 0; g < gap; g++) begin
        s_valid = 1'b0;
        tick();
        check("gap_sready", 32'(s_ready), 1);
        check("gap_we",     32'(mem_we), 0);
      end
      sum = sum + w[i];
      send_beat(i, sum, poke && i == 1);
    end
    // VERIFY cycle: an extra offered beat must not be taken.
    s_valid = 1'b1;
    s_data  = 16'h5A5A;
    check("vfy_sready", 32'(s_ready), 0);
    check("vfy_memrdy", 32'(memory_ready), 1);
    check("vfy_wload",  32'(weights_loaded), 0);
    tick();
    s_valid = 1'b0;
    pass = (sum == exp_sum);
    check("res_wload",  32'(weights_loaded), 32'(pass));
    check("res_lderr",  32'(load_error), 32'(!pass));
    check("res_memrdy", 32'(memory_ready), 1);
    check("res_sready", 32'(s_ready), 0);
    check("res_we",     32'(mem_we), 0);
    check("res_words",  32'(words_loaded), NW);
    check("res_csum",   32'(checksum), 32'(sum));
    for (int k = 0; k < DEPTH; k++)
      check($sformatf("res_shadow%0d", k), 32'(shadow[k]), (k < NW) ? 32'(w[k]) : 0);
    check("res_bad_addr", 32'(bad_addr), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WIDTH-1:0] ref_sum;
    rst = 1'b1;
    start = 1'b0;
    s_valid = 1'b0;
    s_data = '0;
    expected_checksum = '0;
    repeat (3) tick();
    rst = 1'b0;
    check_reset_state("reset");

    // Clear sweep, then a passing load.
    start_and_clear(1'b0);
    w = '{16'h0001, 16'h0002, 16'h0003, 16'h0004};
    run_load(16'h000A, 0, 1'b0);

    // Same stream, wrong reference checksum.
    start_and_clear(1'b0);
    run_load(16'h000B, 0, 1'b0);

    // Checksum wrap with 3-cycle gaps between beats.
    start_and_clear(1'b0);
    w = '{16'hFFFF, 16'h0002, 16'h0000, 16'h0000};
    run_load(16'h0001, 3, 1'b0);

    // Timeout: two beats, then 16 idle LOAD cycles.
    start_and_clear(1'b0);
    for (int i = 0; i < NW; i++) w[i] = 16'($urandom);
    ref_sum = w[0];
    send_beat(0, ref_sum, 1'b0);
    ref_sum = ref_sum + w[1];
    send_beat(1, ref_sum, 1'b0);
    for (int j = 1; j < TLIM; j++) begin
      tick();
      check($sformatf("to_sready%0d", j), 32'(s_ready), 1);
    end
    tick();
    check("to_lderr",  32'(load_error), 1);
    check("to_sready", 32'(s_ready), 0);
    check("to_memrdy", 32'(memory_ready), 1);
    check("to_wload",  32'(weights_loaded), 0);
    check("to_words",  32'(words_loaded), 2);
    start_and_clear(1'b0);

    // Reset mid-LOAD with a beat on offer; the pending write must be cancelled.
    for (int i = 0; i < NW; i++) w[i] = 16'($urandom);
    ref_sum = w[0];
    send_beat(0, ref_sum, 1'b0);
    ref_sum = ref_sum + w[1];
    send_beat(1, ref_sum, 1'b0);
    s_valid = 1'b1;
    s_data  = w[2];
    rst     = 1'b1;
    tick();
    rst     = 1'b0;
    s_valid = 1'b0;
    check_reset_state("midrst");
    tick();
    check_reset_state("midrst_hold");

    // Start pulses during CLEAR and LOAD are ignored.
    start_and_clear(1'b1);
    for (int i = 0; i < NW; i++) w[i] = 16'($urandom);
    run_load(model_sum(), 0, 1'b1);

    // Random weight sets, random gaps, random pass/fail reference.
    for (int r = 0; r < 4; r++) begin
      start_and_clear(1'b0);
      for (int i = 0; i < NW; i++) w[i] = 16'($urandom);
      ref_sum = model_sum();
      if ($urandom_range(0, 1) == 0) ref_sum = ref_sum ^ 16'($urandom_range(1, 65535));
      run_load(ref_sum, int'($urandom_range(0, 2)), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
